// File: rtl/generic_wrr_frame_sched.sv
// Weighted round-robin frame scheduler: grants one source for up to cfg_weight whole frames
// (header + last beat) per turn, then rotates to the next eligible source.
module generic_wrr_frame_sched #(
  parameter int S_COUNT      = 4,
  parameter int WEIGHT_WIDTH = 4,
  parameter int CNT_WIDTH    = 16,
  localparam int CL_S_COUNT  = $clog2(S_COUNT)
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic [S_COUNT-1:0]              req,
  input  logic [S_COUNT-1:0]              hdr_ack,
  input  logic [S_COUNT-1:0]              last_ack,
  input  logic [S_COUNT*WEIGHT_WIDTH-1:0] cfg_weight,
  input  logic [S_COUNT-1:0]              cfg_enable,
  output logic [S_COUNT-1:0]              grant,
  output logic                            grant_valid,
  output logic [CL_S_COUNT-1:0]           grant_encoded,
  output logic [WEIGHT_WIDTH-1:0]         quantum_left,
  output logic [CNT_WIDTH-1:0]            stat_frame_count
);

  typedef enum logic {IDLE, GRANT} state_t;

  state_t                  state, state_d;
  logic [S_COUNT-1:0]      grant_d;
  logic [CL_S_COUNT-1:0]   grant_encoded_d;
  logic [CL_S_COUNT-1:0]   last_granted, last_granted_d;
  logic [WEIGHT_WIDTH-1:0] quantum_left_d;
  logic [CNT_WIDTH-1:0]    stat_frame_count_d;
  logic                    hdr_seen, hdr_seen_d;
  logic                    last_seen, last_seen_d;

  logic [S_COUNT-1:0]      eligible;
  logic                    pick_found;
  logic [CL_S_COUNT-1:0]   pick_idx;
  logic [S_COUNT-1:0]      pick_onehot;
  logic [WEIGHT_WIDTH-1:0] pick_weight;
  logic                    hdr_now, last_now, frame_done;

  assign eligible    = req & cfg_enable;
  assign grant_valid = (state == GRANT);

  // Rotating priority search starting just after the previously served source.
  always_comb begin : rr_pick
    int                    cand;
    logic [CL_S_COUNT-1:0] cand_idx;
    cand        = 0;
    cand_idx    = '0;
    pick_found  = 1'b0;
    pick_idx    = '0;
    for (int off = 1; off <= S_COUNT; off++) begin
      cand = int'(last_granted) + off;
      if (cand >= S_COUNT) cand = cand - S_COUNT;
      cand_idx = CL_S_COUNT'(cand);
      if (!pick_found && eligible[cand_idx]) begin
        pick_found = 1'b1;
        pick_idx   = cand_idx;
      end
    end
  end

  always_comb begin
    pick_onehot           = '0;
    pick_onehot[pick_idx] = 1'b1;
    pick_weight           = cfg_weight[int'(pick_idx)*WEIGHT_WIDTH +: WEIGHT_WIDTH];
  end

  // Only the granted source's acks count; they may land in either order or together.
  assign hdr_now    = hdr_seen  | hdr_ack[grant_encoded];
  assign last_now   = last_seen | last_ack[grant_encoded];
  assign frame_done = (state == GRANT) && hdr_now && last_now;

  always_comb begin
    state_d            = state;
    grant_d            = grant;
    grant_encoded_d    = grant_encoded;
    last_granted_d     = last_granted;
    quantum_left_d     = quantum_left;
    stat_frame_count_d = stat_frame_count;
    hdr_seen_d         = hdr_seen;
    last_seen_d        = last_seen;
    case (state)
      IDLE: begin
        if (pick_found) begin
          state_d         = GRANT;
          grant_d         = pick_onehot;
          grant_encoded_d = pick_idx;
          quantum_left_d  = (pick_weight == '0) ? WEIGHT_WIDTH'(1) : pick_weight;
          hdr_seen_d      = 1'b0;
          last_seen_d     = 1'b0;
        end
      end
      GRANT: begin
        if (frame_done) begin
          hdr_seen_d         = 1'b0;
          last_seen_d        = 1'b0;
          stat_frame_count_d = stat_frame_count + CNT_WIDTH'(1);
          quantum_left_d     = quantum_left - WEIGHT_WIDTH'(1);
          if (!(quantum_left > WEIGHT_WIDTH'(1) && eligible[grant_encoded])) begin
            state_d        = IDLE;
            grant_d        = '0;
            last_granted_d = grant_encoded;
          end
        end else begin
          hdr_seen_d  = hdr_now;
          last_seen_d = last_now;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state            <= IDLE;
      grant            <= '0;
      grant_encoded    <= '0;
      last_granted     <= CL_S_COUNT'(S_COUNT - 1);
      quantum_left     <= '0;
      stat_frame_count <= '0;
      hdr_seen         <= 1'b0;
      last_seen        <= 1'b0;
    end else begin
      state            <= state_d;
      grant            <= grant_d;
      grant_encoded    <= grant_encoded_d;
      last_granted     <= last_granted_d;
      quantum_left     <= quantum_left_d;
      stat_frame_count <= stat_frame_count_d;
      hdr_seen         <= hdr_seen_d;
      last_seen        <= last_seen_d;
    end
  end

endmodule

// File: tb/tb_generic_wrr_frame_sched.sv
// Directed bench for generic_wrr_frame_sched (4 sources, 4-bit weights, 16-bit counter).
module tb_generic_wrr_frame_sched;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [3:0]  req = '0;
  logic [3:0]  hdr_ack = '0;
  logic [3:0]  last_ack = '0;
  logic [15:0] cfg_weight = 16'h1111;
  logic [3:0]  cfg_enable = 4'b1111;
  logic [3:0]  grant;
  logic        grant_valid;
  logic [1:0]  grant_encoded;
  logic [3:0]  quantum_left;
  logic [15:0] stat_frame_count;

  int n_cmp = 0;
  int n_bad = 0;

  generic_wrr_frame_sched #(
    .S_COUNT(4), .WEIGHT_WIDTH(4), .CNT_WIDTH(16)
  ) dut (
    .clk(clk), .rst(rst), .req(req), .hdr_ack(hdr_ack), .last_ack(last_ack),
    .cfg_weight(cfg_weight), .cfg_enable(cfg_enable), .grant(grant),
    .grant_valid(grant_valid), .grant_encoded(grant_encoded),
    .quantum_left(quantum_left), .stat_frame_count(stat_frame_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
    end
  endtask

  // Inputs change and outputs are sampled on the falling edge.
  task automatic step();
    @(negedge clk);
  endtask

  task automatic acks(input logic [3:0] h, input logic [3:0] l);
    hdr_ack  = h;
    last_ack = l;
  endtask

  initial begin
    step();
    chk("rst_grant", 32'(grant), 0);
    chk("rst_gv", 32'(grant_valid), 0);
    chk("rst_enc", 32'(grant_encoded), 0);
    chk("rst_ql", 32'(quantum_left), 0);
    chk("rst_cnt", 32'(stat_frame_count), 0);
    rst = 1'b0;

    // Plain round robin between sources 1 and 3, weight 1.
    step();
    req = 4'b1010;
    step();
    chk("rr_g1", 32'(grant), 'h2);
    chk("rr_gv1", 32'(grant_valid), 1);
    chk("rr_enc1", 32'(grant_encoded), 1);
    chk("rr_ql1", 32'(quantum_left), 1);
    acks(4'b0010, 4'b0010);
    step();
    chk("rr_gap1", 32'(grant_valid), 0);
    chk("rr_gap1_grant", 32'(grant), 0);
    chk("rr_enc_hold", 32'(grant_encoded), 1);
    chk("rr_cnt1", 32'(stat_frame_count), 1);
    acks(4'b0000, 4'b0000);
    step();
    chk("rr_g2", 32'(grant), 'h8);
    chk("rr_enc2", 32'(grant_encoded), 3);
    acks(4'b1000, 4'b1000);
    step();
    chk("rr_gap2", 32'(grant_valid), 0);
    chk("rr_cnt2", 32'(stat_frame_count), 2);
    acks(4'b0000, 4'b0000);
    step();
    chk("rr_g3", 32'(grant), 'h2);
    acks(4'b0010, 4'b0010);
    step();
    chk("rr_cnt3", 32'(stat_frame_count), 3);
    acks(4'b0000, 4'b0000);
    req = 4'b0000;
    step();
    chk("rr_idle", 32'(grant_valid), 0);

    // Weight 3 on source 0: three back-to-back frames, then source 1.
    cfg_weight = 16'h0013;
    req = 4'b0011;
    step();
    chk("w3_g", 32'(grant), 'h1);
    chk("w3_ql3", 32'(quantum_left), 3);
    acks(4'b0001, 4'b0001);
    step();
    chk("w3_gv_a", 32'(grant_valid), 1);
    chk("w3_g_a", 32'(grant), 'h1);
    chk("w3_ql2", 32'(quantum_left), 2);
    chk("w3_cnt4", 32'(stat_frame_count), 4);
    acks(4'b0000, 4'b0000);
    step();
    acks(4'b0001, 4'b0001);
    step();
    chk("w3_gv_b", 32'(grant_valid), 1);
    chk("w3_ql1", 32'(quantum_left), 1);
    chk("w3_cnt5", 32'(stat_frame_count), 5);
    acks(4'b0000, 4'b0000);
    step();
    acks(4'b0001, 4'b0001);
    step();
    chk("w3_end_gv", 32'(grant_valid), 0);
    chk("w3_end_ql", 32'(quantum_left), 0);
    chk("w3_cnt6", 32'(stat_frame_count), 6);
    acks(4'b0000, 4'b0000);
    step();
    chk("w3_next", 32'(grant), 'h2);
    chk("w3_next_ql", 32'(quantum_left), 1);
    acks(4'b0010, 4'b0010);
    step();
    chk("w3_cnt7", 32'(stat_frame_count), 7);
    acks(4'b0000, 4'b0000);
    req = 4'b0000;
    cfg_weight = 16'h1111;
    step();

    // last_ack first, hdr_ack two cycles later: one completion.
    req = 4'b0100;
    step();
    chk("ord_g", 32'(grant), 'h4);
    acks(4'b0000, 4'b0100);
    step();
    chk("ord_gv_a", 32'(grant_valid), 1);
    chk("ord_cnt_a", 32'(stat_frame_count), 7);
    acks(4'b0000, 4'b0000);
    step();
    chk("ord_gv_b", 32'(grant_valid), 1);
    acks(4'b0100, 4'b0000);
    step();
    chk("ord_done", 32'(grant_valid), 0);
    chk("ord_cnt", 32'(stat_frame_count), 8);
    acks(4'b0000, 4'b0000);
    step();

    // Acks on non-granted sources are ignored.
    chk("ng_g", 32'(grant), 'h4);
    acks(4'b1011, 4'b1011);
    step();
    chk("ng_gv", 32'(grant_valid), 1);
    chk("ng_grant", 32'(grant), 'h4);
    chk("ng_cnt", 32'(stat_frame_count), 8);
    acks(4'b0100, 4'b0000);
    step();
    acks(4'b0000, 4'b0001);
    step();
    chk("ng_half", 32'(grant_valid), 1);
    chk("ng_half_cnt", 32'(stat_frame_count), 8);
    acks(4'b0000, 4'b0100);
    step();
    chk("ng_done", 32'(grant_valid), 0);
    chk("ng_cnt2", 32'(stat_frame_count), 9);
    acks(4'b0000, 4'b0000);

    // Source 2 masked off; source 1 weight 0 acts as 1.
    cfg_enable = 4'b1011;
    cfg_weight = 16'h1101;
    req = 4'b0110;
    step();
    chk("en_g", 32'(grant), 'h2);
    chk("w0_ql", 32'(quantum_left), 1);
    acks(4'b0010, 4'b0010);
    step();
    chk("w0_end", 32'(grant_valid), 0);
    chk("w0_cnt", 32'(stat_frame_count), 10);
    acks(4'b0000, 4'b0000);
    step();
    chk("en_skip", 32'(grant), 'h2);

    // Reset mid-frame, after the header but before the last beat.
    req = 4'b1111;
    cfg_enable = 4'b1111;
    acks(4'b0010, 4'b0000);
    step();
    acks(4'b0000, 4'b0000);
    rst = 1'b1;
    #1;
    chk("mr_grant", 32'(grant), 0);
    chk("mr_gv", 32'(grant_valid), 0);
    chk("mr_enc", 32'(grant_encoded), 0);
    chk("mr_ql", 32'(quantum_left), 0);
    chk("mr_cnt", 32'(stat_frame_count), 0);
    step();
    rst = 1'b0;
    step();
    chk("mr_first", 32'(grant), 'h1);
    acks(4'b0000, 4'b0001);
    step();
    chk("mr_flag_clr", 32'(grant_valid), 1);
    chk("mr_cnt0", 32'(stat_frame_count), 0);
    acks(4'b0000, 4'b0000);
    step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/generic_wrr_frame_sched.md
GENERIC_WRR_FRAME_SCHED -- requirements
Module: generic_wrr_frame_sched

Interface
REQ-001 SHALL have parameter S_COUNT, default 4: number of requesting sources (2..16).
REQ-002 SHALL have parameter WEIGHT_WIDTH, default 4: width of each per-source weight field.
REQ-003 SHALL have parameter CNT_WIDTH, default 16: width of the completed-frame counter.
REQ-004 SHALL derive CL_S_COUNT = $clog2(S_COUNT) for encoded widths.
REQ-005 SHALL have port clk, input, 1: single clock; all logic on its rising edge.
REQ-006 SHALL have port rst, input, 1: reset, asynchronous and active-high.
REQ-007 SHALL have port req, input, S_COUNT: per-source header valid, used as the arbitration request.
REQ-008 SHALL have port hdr_ack, input, S_COUNT: per-source header handshake (hdr_valid & hdr_ready).
REQ-009 SHALL have port last_ack, input, S_COUNT: per-source payload last beat accepted (tvalid & tready & tlast).
REQ-010 SHALL have port cfg_weight, input, S_COUNT*WEIGHT_WIDTH: frames per turn for each source, source i in bits [i*WEIGHT_WIDTH +: WEIGHT_WIDTH].
REQ-011 SHALL have port cfg_enable, input, S_COUNT: per-source eligibility mask.
REQ-012 SHALL have port grant, output, S_COUNT: one-hot grant, registered.
REQ-013 SHALL have port grant_valid, output, 1: a grant is active, registered.
REQ-014 SHALL have port grant_encoded, output, CL_S_COUNT: binary index of the granted source, registered.
REQ-015 SHALL have port quantum_left, output, WEIGHT_WIDTH: frames remaining in the current turn, including the one in flight.
REQ-016 SHALL have port stat_frame_count, output, CNT_WIDTH: count of completed frames; wraps modulo 2^CNT_WIDTH.

Function
REQ-017 SHALL implement two states: IDLE (grant_valid=0) and GRANT (grant_valid=1).
REQ-018 SHALL define a source as eligible when req[i] & cfg_enable[i] is true.
REQ-019 IDLE: if any source is eligible, SHALL enter GRANT at the next edge, with grant/grant_encoded set to the chosen source.
REQ-020 SHALL choose the first eligible source in ascending index order, starting at last_granted+1 and wrapping modulo S_COUNT; last_granted resets to S_COUNT-1, so source 0 wins first.
REQ-021 On entering GRANT, SHALL load quantum_left with cfg_weight of the granted source; a weight of 0 SHALL be treated as 1.
REQ-022 In GRANT, SHALL track hdr_seen and last_seen flags from hdr_ack and last_ack of the granted source only; acks from other sources SHALL be ignored.
REQ-023 A frame SHALL be complete in the cycle where both flags are, or become, set; hdr_ack and last_ack may arrive in either order or in the same cycle.
REQ-024 On frame completion, SHALL clear both flags, increment stat_frame_count, and decrement quantum_left.
REQ-025 On completion, if quantum_left > 1 and the granted source is still eligible, SHALL remain in GRANT with grant unchanged (back-to-back frames, no gap).
REQ-026 On completion in every other case, SHALL go to IDLE and update last_granted; grant_valid=0 for at least one cycle before the next grant.
REQ-027 Changes to cfg_weight SHALL take effect only at the next GRANT entry.
REQ-028 Deasserting cfg_enable or req during GRANT SHALL NOT abort the in-flight frame; it only prevents continuation.
REQ-029 grant SHALL always be one-hot, or all zero in IDLE.
REQ-030 grant_encoded SHALL hold its last value while in IDLE.

Reset
REQ-031 While rst=1, SHALL force IDLE, grant=0, grant_valid=0, grant_encoded=0, quantum_left=0, stat_frame_count=0, flags cleared, last_granted=S_COUNT-1.
REQ-032 Reset asserted mid-frame SHALL abandon the frame without incrementing the count; after release, arbitration SHALL restart from source 0.

Verification
REQ-033 SHALL verify: req=4'b1010, all weights 1 -> grant=0010, then 1000 after that frame, then 0010 again; 1-cycle grant_valid gap between grants.
REQ-034 SHALL verify: weight[0]=3, req[0] held, req[1]=1 -> 3 back-to-back frames on source 0, quantum_left 3,2,1, then grant moves to source 1.
REQ-035 SHALL verify: last_ack then hdr_ack two cycles later, and separately both acks in the same cycle -> exactly one completion each; stat_frame_count +1 per frame.
REQ-036 SHALL verify: ack pulses on a non-granted source -> no state change and no count change.
REQ-037 SHALL verify: cfg_enable[2]=0 with req[2]=1 -> source 2 never granted; a weight of 0 behaves as 1.
REQ-038 SHALL verify: rst pulse after hdr_ack but before last_ack -> all outputs return to 0, and the next grant goes to the lowest-index eligible source.
